key_line_driver: RTL and testbench
==================================

Name: key_line_driver

Overview:
- Decoder-side counterpart of the dual-148 priority-encoder to 4511 display path.
- Accepts 4-bit key codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as one active-low one-hot strobe on two 8-bit key-line buses (I1 = codes 0-7, I2 = codes 8-15), framed by an active-low enable EI.
- Used as the on-board stimulus source driving the encoder/display chain during lab demos and regression.

Parameters:
HOLD_CYCLES, 16, cycles the selected key line is held low; legal range 1..255
GAP_CYCLES, 4, cycles all lines are released after a strobe; legal range 0..255 (0 skips GAP)
FIFO_DEPTH, 4, code FIFO entries; power of two, 2..16

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
CODE  input  4  key code to replay
CODE_VALID  input  1  CODE is valid this cycle
CODE_READY  output  1  FIFO can accept a code this cycle
I1  output  8  active-low key lines for codes 0-7; bit n low means code n
I2  output  8  active-low key lines for codes 8-15; bit n low means code 8+n
EI  output  1  active-low enable for the downstream encoder
BUSY  output  1  high while the FSM is not in IDLE or the FIFO is non-empty

Behaviour:
- Interface: one clock (CLK); RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset values:
  - I1 = 8'hFF, I2 = 8'hFF, EI = 1, BUSY = 0.
  - CODE_READY = 0 during any cycle in which RST is high; it becomes 1 in the first cycle after RST deasserts.
- RST asserted mid-operation: the next edge clears the FIFO, returns the FSM to IDLE and forces the reset output values, whatever the state.
- Handshake:
  - A transfer occurs on an edge where CODE_VALID & CODE_READY are both high.
  - CODE_READY = !RST && (fifo_count < FIFO_DEPTH), computed from the registered count.
  - With a full FIFO, a pop in the same cycle does not allow a push. A code offered while CODE_READY = 0 is not taken; the source holds it.
- FIFO: first in, first out; pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states:
  - IDLE: I1 = I2 = FF, EI = 1. If the FIFO is non-empty, pop the head into code_r and go to SETUP.
  - SETUP (1 cycle): EI = 0, I1 = I2 = FF. Go to HOLD.
  - HOLD (HOLD_CYCLES cycles):
    - EI = 0.
    - If code_r[3] = 0: I1 = ~(1 << code_r[2:0]), I2 = FF.
    - If code_r[3] = 1: I2 = ~(1 << code_r[2:0]), I1 = FF.
    - Exactly one line is low. Go to GAP, or straight to the end-of-strobe decision if GAP_CYCLES = 0.
  - GAP (GAP_CYCLES cycles): EI = 0, I1 = I2 = FF.
  - End of strobe: if the FIFO is non-empty, pop and go to SETUP (EI stays 0, no high glitch); otherwise go to IDLE (EI returns to 1).
- Latency for a code accepted at edge t with the FSM in IDLE and the FIFO previously empty:
  - FIFO non-empty after t; IDLE pops at edge t+1; SETUP outputs visible after edge t+2.
  - Line low from edge t+3 through edge t+3+HOLD_CYCLES-1.
  - Lines released at edge t+3+HOLD_CYCLES.
- Strobe period for back-to-back queued codes: 1 + HOLD_CYCLES + GAP_CYCLES cycles.
- Hold/gap counter: 8 bits. It loads on state entry and counts down to 1; the state exits on the edge where the count is 1.
- BUSY = (state != IDLE) || (fifo_count != 0). It is registered alongside the state.
- A push while the FSM is in HOLD/GAP never alters the line currently asserted.

Test Plan:
- Reset, then push CODE=3 at edge t (HOLD=16, GAP=4): EI=0 from t+2; I1=8'hF7, I2=8'hFF for exactly 16 cycles from t+3; I1=FF at t+19; EI=1 at t+23; BUSY falls at the same edge.
- Push CODE=12: I2=8'hEF, I1=8'hFF during HOLD; never more than one line low at any cycle across all 16 codes.
- Push 0,15,7,8 back-to-back (FIFO_DEPTH=4): four strobes in order, each period 21 cycles; EI stays 0 throughout the burst.
- Hold CODE_VALID high continuously with a slow drain: CODE_READY falls at count=4; no fifth code is accepted; all accepted codes are replayed in order with no duplicates.
- Assert RST for one cycle mid-HOLD with 2 codes queued: next cycle I1=I2=FF, EI=1, BUSY=0; no queued code is replayed afterwards.
- GAP_CYCLES=0, HOLD_CYCLES=1: codes 5 then 6 give I1=DF for one cycle, one SETUP cycle with FF, then I1=BF for one cycle.

Source files
------------

// File: rtl/key_line_driver.sv
// key_line_driver: buffers 4-bit key codes in a small FIFO and replays each one
// as a single active-low strobe on two 8-bit key-line buses, framed by an
// active-low enable. Sequence per code: SETUP (1) -> HOLD -> GAP -> next/IDLE.
module key_line_driver #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] CODE,
    input  logic       CODE_VALID,
    output logic       CODE_READY,
    output logic [7:0] I1,
    output logic [7:0] I2,
    output logic       EI,
    output logic       BUSY
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam logic [7:0]       GAP_LOAD  = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Code FIFO storage and bookkeeping
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;

    // Strobe sequencer
    state_t     state_reg;
    state_t     state_next;
    logic [7:0] timer_reg;
    logic [7:0] timer_next;
    logic [3:0] code_reg;

    // Registered outputs
    logic [7:0] i1_reg;
    logic [7:0] i1_next;
    logic [7:0] i2_reg;
    logic [7:0] i2_next;
    logic       ei_reg;
    logic       ei_next;
    logic       busy_reg;
    logic       busy_next;

    // One-hot (active-high) selection of the line within the chosen bus
    logic [7:0] line_sel;

    // Ready is taken from the registered count, so a pop cannot free a slot
    // for a push in the same cycle.
    assign CODE_READY = !RST && (count_reg < DEPTH_C);
    assign push       = CODE_VALID && CODE_READY;

    // FIFO storage: written on an accepted transfer, no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= CODE;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sequencer state, dwell timer and the code being replayed (loaded on pop)
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            timer_reg <= 8'd0;
            code_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            if (pop) begin
                code_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    // Next-state logic; the timer loads on entry and the state exits when it reads 1
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = HOLD;
                timer_next = HOLD_LOAD;
            end
            HOLD: begin
                if (timer_reg == 8'd1) begin
                    if (GAP_LOAD != 8'd0) begin
                        state_next = GAP;
                        timer_next = GAP_LOAD;
                    end else if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 8'd1;
                end
            end
            GAP: begin
                if (timer_reg == 8'd1) begin
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-line decode of the low three code bits
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line_sel
            assign line_sel[gi] = (code_reg[2:0] == 3'(gi));
        end
    endgenerate

    // Output values for the current state; registered on the next edge
    always_comb begin
        i1_next   = 8'hFF;
        i2_next   = 8'hFF;
        ei_next   = 1'b1;
        busy_next = (state_reg != IDLE) || (count_reg != '0);
        case (state_reg)
            IDLE: begin
                ei_next = 1'b1;
            end
            SETUP, GAP: begin
                ei_next = 1'b0;
            end
            HOLD: begin
                ei_next = 1'b0;
                if (code_reg[3]) begin
                    i2_next = ~line_sel;
                end else begin
                    i1_next = ~line_sel;
                end
            end
            default: begin
                ei_next = 1'b1;
            end
        endcase
    end

    // Output registers; reset forces all lines released and the enable inactive
    always_ff @(posedge CLK) begin
        if (RST) begin
            i1_reg   <= 8'hFF;
            i2_reg   <= 8'hFF;
            ei_reg   <= 1'b1;
            busy_reg <= 1'b0;
        end else begin
            i1_reg   <= i1_next;
            i2_reg   <= i2_next;
            ei_reg   <= ei_next;
            busy_reg <= busy_next;
        end
    end

    assign I1   = i1_reg;
    assign I2   = i2_reg;
    assign EI   = ei_reg;
    assign BUSY = busy_reg;

endmodule

// File: tb/tb_key_line_driver.sv
// Directed bench for key_line_driver: default instance (HOLD=16, GAP=4, depth 4)
// plus a short-timing instance (HOLD=1, GAP=0) for the back-to-back corner case.
module tb_key_line_driver;

    logic       clk;
    logic       rst;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] i1;
    logic [7:0] i2;
    logic       ei;
    logic       busy;

    logic [3:0] code2;
    logic       valid2;
    logic       ready2;
    logic [7:0] i1b;
    logic [7:0] i2b;
    logic       eib;
    logic       busyb;

    int tests;
    int fails;
    int cyc;

    logic [3:0] seen[$];
    int         starts[$];
    logic       prev_low;

    typedef struct {
        logic [3:0] code;
        logic [7:0] i1;
        logic [7:0] i2;
    } vec_t;

    vec_t tbl [16];

    key_line_driver #(.HOLD_CYCLES(16), .GAP_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RST(rst), .CODE(code), .CODE_VALID(code_valid),
        .CODE_READY(code_ready), .I1(i1), .I2(i2), .EI(ei), .BUSY(busy)
    );

    key_line_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut2 (
        .CLK(clk), .RST(rst), .CODE(code2), .CODE_VALID(valid2),
        .CODE_READY(ready2), .I1(i1b), .I2(i2b), .EI(eib), .BUSY(busyb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] decode(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (b[i] == 1'b0) r = 4'(8 + i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (a[i] == 1'b0) r = 4'(i);
        end
        return r;
    endfunction

    // Records the code and start cycle of every new strobe on the main DUT
    task automatic observe();
        logic low_now;
        low_now = (i1 != 8'hFF) || (i2 != 8'hFF);
        if (low_now && !prev_low) begin
            seen.push_back(decode(i1, i2));
            starts.push_back(cyc);
        end
        prev_low = low_now;
    endtask

    task automatic push(input logic [3:0] c);
        logic xfer;
        xfer = 1'b0;
        code = c;
        code_valid = 1'b1;
        for (int w = 0; w < 100 && !xfer; w++) begin
            xfer = code_ready;
            step();
            observe();
        end
        code_valid = 1'b0;
        if (!xfer) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: code %0h not accepted, expected acceptance", c);
        end
    endtask

    initial begin
        logic [3:0]  seq [8];
        logic [3:0]  acc [$];
        logic [7:0]  e2_i1 [8];
        logic        e2_ei [8];
        int          low_cnt;
        int          bad_cnt;
        int          glitch;
        int          idx;
        logic        active;
        logic        found;
        logic        xfer;
        logic        ready_dropped;
        logic [3:0]  burst [4];

        tbl[0]  = '{4'd0,  8'hFE, 8'hFF};
        tbl[1]  = '{4'd1,  8'hFD, 8'hFF};
        tbl[2]  = '{4'd2,  8'hFB, 8'hFF};
        tbl[3]  = '{4'd3,  8'hF7, 8'hFF};
        tbl[4]  = '{4'd4,  8'hEF, 8'hFF};
        tbl[5]  = '{4'd5,  8'hDF, 8'hFF};
        tbl[6]  = '{4'd6,  8'hBF, 8'hFF};
        tbl[7]  = '{4'd7,  8'h7F, 8'hFF};
        tbl[8]  = '{4'd8,  8'hFF, 8'hFE};
        tbl[9]  = '{4'd9,  8'hFF, 8'hFD};
        tbl[10] = '{4'd10, 8'hFF, 8'hFB};
        tbl[11] = '{4'd11, 8'hFF, 8'hF7};
        tbl[12] = '{4'd12, 8'hFF, 8'hEF};
        tbl[13] = '{4'd13, 8'hFF, 8'hDF};
        tbl[14] = '{4'd14, 8'hFF, 8'hBF};
        tbl[15] = '{4'd15, 8'hFF, 8'h7F};

        tests = 0; fails = 0; cyc = 0; prev_low = 1'b0;
        rst = 1'b1; code = 4'd0; code_valid = 1'b0; code2 = 4'd0; valid2 = 1'b0;

        // Reset state
        step(); step();
        check("rst_i1", i1, 8'hFF);
        check("rst_i2", i2, 8'hFF);
        check("rst_ei", ei, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready_low", code_ready, 1'b0);
        rst = 1'b0;
        step();
        check("ready_after_rst", code_ready, 1'b1);
        check("ready2_after_rst", ready2, 1'b1);

        // Single code 3: cycle-by-cycle timing relative to the accepting edge
        push(4'd3);
        for (int k = 1; k <= 24; k++) begin
            step();
            observe();
            check($sformatf("t3_i1_k%0d", k), i1, (k >= 3 && k <= 18) ? 8'hF7 : 8'hFF);
            check($sformatf("t3_i2_k%0d", k), i2, 8'hFF);
            check($sformatf("t3_ei_k%0d", k), ei, (k >= 2 && k <= 22) ? 1'b0 : 1'b1);
            check($sformatf("t3_busy_k%0d", k), busy, (k <= 22) ? 1'b1 : 1'b0);
        end

        // Table: every code, hold length, single-line rule and decoded identity
        for (int v = 0; v < 16; v++) begin
            seen.delete();
            starts.delete();
            push(tbl[v].code);
            low_cnt = 0;
            bad_cnt = 0;
            for (int k = 1; k <= 24; k++) begin
                step();
                observe();
                if (i1 == tbl[v].i1 && i2 == tbl[v].i2) low_cnt++;
                else if (!(i1 == 8'hFF && i2 == 8'hFF)) bad_cnt++;
            end
            check($sformatf("tbl_hold_len_code%0d", v), low_cnt, 16);
            check($sformatf("tbl_bad_lines_code%0d", v), bad_cnt, 0);
            check($sformatf("tbl_strobes_code%0d", v), seen.size(), 1);
            if (seen.size() == 1) check($sformatf("tbl_decoded_code%0d", v), seen[0], tbl[v].code);
            check($sformatf("tbl_idle_code%0d", v), busy, 1'b0);
        end

        // Burst 0,15,7,8: order, 21-cycle period, EI held low across the burst
        burst[0] = 4'd0; burst[1] = 4'd15; burst[2] = 4'd7; burst[3] = 4'd8;
        seen.delete();
        starts.delete();
        active = 1'b0;
        glitch = 0;
        for (int b = 0; b < 4; b++) push(burst[b]);
        for (int c = 0; c < 200; c++) begin
            step();
            observe();
            if (ei == 1'b0) active = 1'b1;
            if (active && ei && seen.size() < 4) glitch++;
            if (seen.size() == 4 && !busy) break;
        end
        check("burst_count", seen.size(), 4);
        check("burst_ei_glitch", glitch, 0);
        check("burst_idle_end", busy, 1'b0);
        if (seen.size() == 4) begin
            for (int b = 0; b < 4; b++) check($sformatf("burst_order%0d", b), seen[b], burst[b]);
            for (int b = 1; b < 4; b++) check($sformatf("burst_period%0d", b), starts[b] - starts[b-1], 21);
        end

        // Back-pressure: VALID held high, 8 codes, slow drain
        seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4;  seq[3] = 4'd8;
        seq[4] = 4'd14; seq[5] = 4'd13; seq[6] = 4'd11; seq[7] = 4'd6;
        seen.delete();
        starts.delete();
        acc.delete();
        idx = 0;
        ready_dropped = 1'b0;
        code = seq[0];
        code_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            xfer = code_valid && code_ready;
            step();
            observe();
            if (xfer) begin
                acc.push_back(code);
                idx++;
                if (idx < 8) code = seq[idx];
                else code_valid = 1'b0;
            end
            if (!ready_dropped && code_valid && !code_ready) begin
                ready_dropped = 1'b1;
                check("bp_accepted_at_full", acc.size(), 5);
            end
            if (idx == 8 && seen.size() == 8 && !busy) break;
        end
        code_valid = 1'b0;
        check("bp_ready_dropped", ready_dropped, 1'b1);
        check("bp_accepted", acc.size(), 8);
        check("bp_replayed", seen.size(), 8);
        if (seen.size() == 8) begin
            for (int b = 0; b < 8; b++) check($sformatf("bp_order%0d", b), seen[b], seq[b]);
        end

        // Reset mid-HOLD with two codes queued
        push(4'd9); push(4'd10); push(4'd11);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            observe();
            if (i2 != 8'hFF) found = 1'b1;
        end
        check("mid_rst_hold_reached", found, 1'b1);
        step(); step(); step();
        observe();
        rst = 1'b1;
        step();
        check("mid_rst_i1", i1, 8'hFF);
        check("mid_rst_i2", i2, 8'hFF);
        check("mid_rst_ei", ei, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready_low", code_ready, 1'b0);
        rst = 1'b0;
        seen.delete();
        starts.delete();
        prev_low = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            observe();
        end
        check("mid_rst_no_replay", seen.size(), 0);
        check("mid_rst_busy_after", busy, 1'b0);
        check("mid_rst_ready_after", code_ready, 1'b1);

        // HOLD=1, GAP=0 instance: codes 5 then 6 back-to-back
        e2_i1[1] = 8'hFF; e2_i1[2] = 8'hFF; e2_i1[3] = 8'hDF; e2_i1[4] = 8'hFF;
        e2_i1[5] = 8'hBF; e2_i1[6] = 8'hFF; e2_i1[7] = 8'hFF; e2_i1[0] = 8'hFF;
        e2_ei[0] = 1'b1; e2_ei[1] = 1'b1; e2_ei[2] = 1'b0; e2_ei[3] = 1'b0;
        e2_ei[4] = 1'b0; e2_ei[5] = 1'b0; e2_ei[6] = 1'b1; e2_ei[7] = 1'b1;
        code2 = 4'd5;
        valid2 = 1'b1;
        step();
        code2 = 4'd6;
        step();
        valid2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            check($sformatf("short_i1_k%0d", k), i1b, e2_i1[k]);
            check($sformatf("short_i2_k%0d", k), i2b, 8'hFF);
            check($sformatf("short_ei_k%0d", k), eib, e2_ei[k]);
        end
        check("short_busy_end", busyb, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
